// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer
// Sits between the sample source, the coefficient shadow/active registers
// and a 4-tap FIR. A commit stalls input, drains the FIR, swaps shadow
// coefficients into the active set, then flushes the delay line with zeros
// and hides the flush outputs. This way no emitted sample mixes old and new
// coefficients or carries old history.
module fir_coeff_sequencer #(
  parameter int data_width  = 16,
  parameter int coeff_width = 16,
  parameter int num_taps    = 4,
  parameter int fir_latency = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [data_width-1:0]  s_data,
  input  logic                   cfg_wr_en,
  input  logic [1:0]             cfg_wr_idx,
  input  logic [coeff_width-1:0] cfg_wr_data,
  input  logic                   cfg_commit,
  output logic                   commit_busy,
  output logic                   commit_done,
  output logic                   fir_valid_in,
  output logic [data_width-1:0]  fir_data_in,
  input  logic                   fir_valid_out,
  input  logic [data_width-1:0]  fir_data_out,
  output logic                   m_valid,
  output logic [data_width-1:0]  m_data,
  output logic [coeff_width-1:0] h0,
  output logic [coeff_width-1:0] h1,
  output logic [coeff_width-1:0] h2,
  output logic [coeff_width-1:0] h3
);

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    SWAP,
    FLUSH,
    SETTLE
  } state_t;

  localparam int cnt_width = $clog2(fir_latency + num_taps + 1);
  localparam logic [cnt_width-1:0] flush_last = cnt_width'(num_taps - 2);
  localparam logic [coeff_width-1:0] coeff_default = coeff_width'(16'h2000);

  state_t                 state;
  state_t                 next_state;
  logic                   pending;
  logic                   commit_req;
  logic [cnt_width-1:0]   inflight;
  logic [cnt_width-1:0]   discard_cnt;
  logic [cnt_width-1:0]   flush_cnt;
  logic                   discard_zero;
  logic                   discard_dec;
  logic [coeff_width-1:0] shadow [4];
  logic [coeff_width-1:0] active [4];

  assign commit_req   = cfg_commit | pending;
  assign commit_busy  = (state != RUN);
  assign discard_zero = (discard_cnt == '0);
  assign discard_dec  = fir_valid_out & ~discard_zero;
  assign m_valid      = fir_valid_out & discard_zero;
  assign m_data       = fir_data_out;
  assign h0           = active[0];
  assign h1           = active[1];
  assign h2           = active[2];
  assign h3           = active[3];

  // State register for the commit sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the input-side handshake and FIR feed
  always_comb begin
    next_state   = state;
    s_ready      = 1'b0;
    fir_valid_in = 1'b0;
    fir_data_in  = '0;
    commit_done  = 1'b0;
    case (state)
      RUN: begin
        s_ready      = enable & ~commit_req & rst_n;
        fir_valid_in = s_valid & s_ready;
        fir_data_in  = s_data;
        if (commit_req) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          next_state = SWAP;
        end
      end
      SWAP: begin
        next_state = FLUSH;
      end
      FLUSH: begin
        fir_valid_in = 1'b1;
        if (flush_cnt == flush_last) begin
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if ((inflight == '0) && discard_zero) begin
          next_state  = RUN;
          commit_done = 1'b1;
        end
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Queue at most one commit requested while a sequence is already running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if ((state == RUN) && commit_req) begin
      pending <= 1'b0;
    end else if (cfg_commit && (state != RUN)) begin
      pending <= 1'b1;
    end
  end

  // Track samples inside the FIR pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (fir_valid_in && !fir_valid_out) begin
      inflight <= inflight + cnt_width'(1);
    end else if (!fir_valid_in && fir_valid_out) begin
      inflight <= inflight - cnt_width'(1);
    end
  end

  // Count flush outputs still to be hidden from the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt <= '0;
    end else if ((state == FLUSH) && !discard_dec) begin
      discard_cnt <= discard_cnt + cnt_width'(1);
    end else if ((state != FLUSH) && discard_dec) begin
      discard_cnt <= discard_cnt - cnt_width'(1);
    end
  end

  // Position within the zero-flush burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if ((state == FLUSH) && (flush_cnt != flush_last)) begin
      flush_cnt <= flush_cnt + cnt_width'(1);
    end else begin
      flush_cnt <= '0;
    end
  end

  // Shadow coefficients accept software writes in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= coeff_default;
      end
    end else if (cfg_wr_en) begin
      shadow[cfg_wr_idx] <= cfg_wr_data;
    end
  end

  // Active coefficients only change at the end of the swap cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        active[i] <= coeff_default;
      end
    end else if (state == SWAP) begin
      for (int i = 0; i < 4; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Testbench for fir_coeff_sequencer with a 4-tap, 3-cycle-latency FIR
// stand-in built from the active coefficients.
module tb_fir_coeff_sequencer;

  localparam int st_run   = 0;
  localparam int st_drain = 1;
  localparam int st_swap  = 2;
  localparam int st_flush = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_idx;
  logic [15:0] cfg_wr_data;
  logic        cfg_commit;
  logic        commit_busy;
  logic        commit_done;
  logic        fir_valid_in;
  logic [15:0] fir_data_in;
  logic        fir_valid_out;
  logic [15:0] fir_data_out;
  logic        m_valid;
  logic [15:0] m_data;
  logic [15:0] h0, h1, h2, h3;

  int checks = 0;
  int passes = 0;

  fir_coeff_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .commit_busy(commit_busy), .commit_done(commit_done),
    .fir_valid_in(fir_valid_in), .fir_data_in(fir_data_in),
    .fir_valid_out(fir_valid_out), .fir_data_out(fir_data_out),
    .m_valid(m_valid), .m_data(m_data),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic signed [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [15:0] dl0, dl1, dl2;
  logic [2:0]  pv;
  logic [15:0] pd0, pd1, pd2;
  logic signed [31:0] acc;

  // Q1.15 dot product of the incoming sample and delay line
  always_comb begin
    acc = sx(fir_data_in) * sx(h0) + sx(dl0) * sx(h1) + sx(dl1) * sx(h2) + sx(dl2) * sx(h3);
  end

  // FIR stand-in: delay line plus three pipeline stages, reset with the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl0 <= '0; dl1 <= '0; dl2 <= '0;
      pv  <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0;
    end else begin
      pv  <= {pv[1:0], fir_valid_in};
      pd0 <= acc[30:15];
      pd1 <= pd0;
      pd2 <= pd1;
      if (fir_valid_in) begin
        dl0 <= fir_data_in;
        dl1 <= dl0;
        dl2 <= dl1;
      end
    end
  end

  assign fir_valid_out = pv[2];
  assign fir_data_out  = pd2;

  int cyc = 0;
  int m_count = 0;
  int discard_count = 0;
  int done_count = 0;
  int swap_count = 0;
  int swap_bad = 0;
  int first_accept = -1;
  int first_out = -1;
  logic [15:0] out_q[$];
  int done_cyc[$];

  // Cycle counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (fir_valid_out) begin
      if (m_valid) begin
        m_count++;
        out_q.push_back(m_data);
      end else begin
        discard_count++;
      end
    end
    if (fir_valid_in && first_accept < 0) first_accept = cyc;
    if (m_valid && first_out < 0) first_out = cyc;
    if (commit_done) begin
      done_count++;
      done_cyc.push_back(cyc);
    end
    if (int'(dut.state) == st_swap) begin
      swap_count++;
      if (dut.inflight != '0) swap_bad++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data);
    s_valid = valid;
    s_data  = data;
    tick();
  endtask

  task automatic writeShadow(input logic [1:0] idx, input logic [15:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_idx  = idx;
    cfg_wr_data = data;
    tick();
    cfg_wr_en   = 1'b0;
  endtask

  task automatic pulseCommit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic waitState(input int st, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (int'(dut.state) == st) found = 1'b1;
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  task automatic waitDone(input int target, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (done_count >= target) found = 1'b1;
    end
    checkOutput(tag, 32'(found), 32'd1);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    int base_m, base_d, base_done, base_swap, t0;
    bit ready_low;

    rst_n = 1'b0; enable = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_wr_data = '0; cfg_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
    checkOutput("rst_fir_valid_in", 32'(fir_valid_in), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("def_h0", 32'(h0), 32'h2000);
    checkOutput("def_h1", 32'(h1), 32'h2000);
    checkOutput("def_h2", 32'(h2), 32'h2000);
    checkOutput("def_h3", 32'(h3), 32'h2000);
    checkOutput("def_busy", 32'(commit_busy), 32'd0);
    checkOutput("def_done", 32'(commit_done), 32'd0);
    checkOutput("def_s_ready", 32'(s_ready), 32'd1);

    // Streaming with default 0.25 taps: outputs ramp 0x400..0x1000
    base_m = m_count;
    ready_low = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h1000;
      #1;
      if (!s_ready) ready_low = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    repeat (6) tick();
    checkOutput("stream_ready_low", 32'(ready_low), 32'd0);
    checkOutput("stream_m_count", 32'(m_count - base_m), 32'd8);
    checkOutput("stream_latency", 32'(first_out - first_accept), 32'd3);
    checkOutput("stream_out0", 32'(out_q[base_m]), 32'h0400);
    checkOutput("stream_out1", 32'(out_q[base_m + 1]), 32'h0800);
    checkOutput("stream_out3", 32'(out_q[base_m + 3]), 32'h1000);
    checkOutput("stream_out7", 32'(out_q[base_m + 7]), 32'h1000);
    checkOutput("stream_inflight", 32'(dut.inflight), 32'd0);

    // enable low blocks acceptance
    enable = 1'b0; s_valid = 1'b1;
    #1;
    checkOutput("enable_low_ready", 32'(s_ready), 32'd0);
    checkOutput("enable_low_fir_valid", 32'(fir_valid_in), 32'd0);
    enable = 1'b1; s_valid = 1'b0;
    tick();

    // Commit mid-stream to taps 0.5,0,0,0
    s_valid = 1'b1; s_data = 16'h1000;
    writeShadow(2'd0, 16'h4000);
    writeShadow(2'd1, 16'h0000);
    writeShadow(2'd2, 16'h0000);
    writeShadow(2'd3, 16'h0000);
    base_d = discard_count; base_done = done_count; base_swap = swap_count;
    cfg_commit = 1'b1;
    #1;
    checkOutput("commit_ready_drop", 32'(s_ready), 32'd0);
    checkOutput("commit_no_feed", 32'(fir_valid_in), 32'd0);
    tick();
    cfg_commit = 1'b0;
    checkOutput("commit_drain_state", 32'(int'(dut.state)), 32'(st_drain));
    waitDone(base_done + 1, "commit_done_seen");
    checkOutput("commit_discards", 32'(discard_count - base_d), 32'd3);
    checkOutput("commit_swap_once", 32'(swap_count - base_swap), 32'd1);
    checkOutput("commit_swap_drained", 32'(swap_bad), 32'd0);
    checkOutput("commit_h0", 32'(h0), 32'h4000);
    checkOutput("commit_h1", 32'(h1), 32'h0000);
    checkOutput("commit_back_run", 32'(commit_busy), 32'd0);
    base_m = m_count;
    applyStimulus(1'b1, 16'h1000);
    s_valid = 1'b0;
    repeat (5) tick();
    checkOutput("post_commit_count", 32'(m_count - base_m), 32'd1);
    checkOutput("post_commit_out", 32'(out_q[base_m]), 32'h0800);

    // Double commit: second request during FLUSH is queued once
    base_done = done_count; base_swap = swap_count;
    t0 = cyc;
    pulseCommit();
    waitState(st_flush, "dbl_reach_flush");
    pulseCommit();
    waitDone(base_done + 1, "dbl_first_done");
    checkOutput("dbl_run_gap", 32'(commit_busy), 32'd0);
    tick();
    checkOutput("dbl_second_start", 32'(commit_busy), 32'd1);
    waitDone(base_done + 2, "dbl_second_done");
    checkOutput("dbl_first_timing", 32'(done_cyc[base_done] - t0), 32'd9);
    checkOutput("dbl_gap_timing", 32'(done_cyc[base_done + 1] - done_cyc[base_done]), 32'd10);
    repeat (20) tick();
    checkOutput("dbl_done_total", 32'(done_count - base_done), 32'd2);
    checkOutput("dbl_swap_total", 32'(swap_count - base_swap), 32'd2);
    checkOutput("dbl_idle", 32'(commit_busy), 32'd0);

    // Shadow write during SWAP is not seen by that swap
    writeShadow(2'd2, 16'h1111);
    base_done = done_count;
    pulseCommit();
    waitState(st_swap, "swapwr_reach_swap");
    writeShadow(2'd2, 16'h7FFF);
    checkOutput("swapwr_h2_old", 32'(h2), 32'h1111);
    waitDone(base_done + 1, "swapwr_done1");
    pulseCommit();
    waitDone(base_done + 2, "swapwr_done2");
    checkOutput("swapwr_h2_new", 32'(h2), 32'h7FFF);

    // Reset during FLUSH restores defaults immediately
    pulseCommit();
    waitState(st_flush, "rstf_reach_flush");
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rstf_state", 32'(int'(dut.state)), 32'(st_run));
    checkOutput("rstf_discard", 32'(dut.discard_cnt), 32'd0);
    checkOutput("rstf_h0", 32'(h0), 32'h2000);
    checkOutput("rstf_h2", 32'(h2), 32'h2000);
    checkOutput("rstf_busy", 32'(commit_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    base_m = m_count;
    s_valid = 1'b1; s_data = 16'h1000;
    #1;
    checkOutput("rstf_ready", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    checkOutput("rstf_m_count", 32'(m_count - base_m), 32'd1);
    checkOutput("rstf_out", 32'(out_q[base_m]), 32'h0400);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Controller that sits between the sample source, the coefficient register file and the 4-tap FIR (`fir_config`). It lets software reprogram coefficients glitch-free while the filter streams. Shadow coefficients are written at any time. A commit request stalls input, drains in-flight samples and swaps shadow to active. It then flushes the delay line with zeros and suppresses the resulting outputs, so no output sample ever mixes old and new coefficients or old history.

## Interface
- `data_width`, 16, sample width
- `coeff_width`, 16, coefficient width (signed Q1.15)
- `num_taps`, 4, FIR tap count; flush length is `num_taps`-1
- `fir_latency`, 3, FIR cycles from `valid_in` to `valid_out`; sizes in-flight counter (clog2(`fir_latency`+`num_taps`+1) bits)

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `enable` in 1 — when 0, no upstream samples accepted (commits still run)
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in `data_width` — upstream sample handshake
- `cfg_wr_en` in 1, `cfg_wr_idx` in 2, `cfg_wr_data` in `coeff_width` — shadow coefficient write
- `cfg_commit` in 1 — one-cycle commit request pulse
- `commit_busy` out 1 — high from commit acceptance until return to RUN
- `commit_done` out 1 — one-cycle pulse on return to RUN
- `fir_valid_in` out 1, `fir_data_in` out `data_width` — to FIR
- `fir_valid_out` in 1, `fir_data_out` in `data_width` — from FIR
- `m_valid` out 1, `m_data` out `data_width` — filtered output, discards removed
- `h0`..`h3` out `coeff_width` each — active coefficients to FIR

## Operation
- States: RUN, DRAIN, SWAP, FLUSH, SETTLE.
- `commit_req` = `cfg_commit` | `pending`.
- RUN behaviour:
  - `s_ready` = `enable` & !`commit_req` (combinational).
  - `fir_valid_in` = `s_valid` & `s_ready`; `fir_data_in` = `s_data`.
  - If `commit_req`, go to DRAIN and clear `pending`.
- DRAIN: `s_ready`=0, `fir_valid_in`=0. When `inflight`==0, go to SWAP.
- SWAP (1 cycle): active coefficients take the shadow values; go to FLUSH.
- FLUSH (`num_taps`-1 cycles):
  - `fir_valid_in`=1, `fir_data_in`=0.
  - Each cycle increments `discard_cnt`.
  - After the last flush cycle, go to SETTLE.
- SETTLE: wait for `inflight`==0 and `discard_cnt`==0. Then go to RUN and pulse `commit_done`.
- In-flight counter: +1 on `fir_valid_in`, -1 on `fir_valid_out`; both in the same cycle means no change.
- Discard: `m_valid` = `fir_valid_out` & (`discard_cnt`==0); `m_data` = `fir_data_out` (combinational). `discard_cnt` decrements on `fir_valid_out` when nonzero; increment and decrement in the same cycle means no change.
- Shadow writes:
  - Allowed in every state.
  - A write to index i in the SWAP cycle is not seen by that swap (old shadow copied); the shadow takes the new value.
- `cfg_commit` handling:
  - While `commit_busy`, `cfg_commit` sets `pending`. At most one commit is queued; extra requests merge into it.
  - `pending` is serviced on the first RUN cycle (one cycle after `commit_done`).
- `commit_busy` = (state != RUN).

## Timing
- Reset values:
  - `s_ready` 0 while in reset, then `enable`-dependent.
  - `fir_valid_in` 0, `fir_data_in` 0, `m_valid` 0.
  - `commit_busy` 0, `commit_done` 0.
  - Active and shadow `h0`..`h3` = 16'h2000.
  - `inflight` 0, `discard_cnt` 0, `pending` 0, state RUN.
- Commit timing:
  - `cfg_commit` at cycle t in RUN: `s_ready` low in cycle t; DRAIN at t+1.
  - With an empty pipe: SWAP t+2, FLUSH t+3..t+5, SETTLE from t+6.
  - Last discarded output at t+5+`fir_latency`. `commit_done` one cycle after that, when SETTLE sees both counters zero and moves to RUN.
- Active coefficients change only at the clock edge ending SWAP. `h*` are registered outputs.
- Passthrough latency is zero cycles (data through, valid gated) in both directions.
- Reset asserted mid-commit returns to RUN immediately and restores default coefficients. Discarded state is lost; the FIR is reset by the same `rst_n`.
- `enable`=0 during a commit has no effect on the commit sequence.

## Test plan
- Reset defaults:
  - Deassert `rst_n` and hold `enable`=1 with no traffic.
  - Required: `h0`..`h3`=16'h2000, `commit_busy`=0, `s_ready`=1.
- Streaming:
  - Send 8 samples of 16'h1000 back-to-back.
  - Required: `s_ready` stays 1; 8 `m_valid` pulses, the first 3 cycles after the first accept; `inflight` returns to 0.
- Commit mid-stream:
  - Write shadow = 16'h4000,0,0,0 and pulse `cfg_commit` while streaming 16'h1000.
  - Required: `s_ready` drops the same cycle; SWAP occurs only when `inflight`==0; exactly 3 FIR outputs are discarded (no `m_valid`).
  - After `commit_done`, the first sample 16'h1000 yields output 16'h0800 (16'h1000 × 0.5), with no old-sample contribution.
- Double commit:
  - Pulse `cfg_commit` during FLUSH.
  - Required: `commit_done` fires, then one RUN cycle, then a second full sequence and a second `commit_done`; no third sequence.
- Shadow write in SWAP:
  - Write index 2 = 16'h7FFF in the SWAP cycle.
  - Required: active `h2` keeps the old shadow value; the next commit applies 16'h7FFF.
- Reset mid-FLUSH:
  - Assert `rst_n`=0 during FLUSH.
  - Required: state RUN, `discard_cnt`=0, `h*`=16'h2000, `commit_busy`=0.
  - After release, the first accepted sample produces a valid `m_valid`.
